// File: rtl/ltssm_config_multilane.sv
// Multi-lane PCIe LTSSM Configuration sub-state machine: link/lane number
// negotiation, lane reversal detection and the TS2/IDLE exchange to link-up.
module ltssm_config_multilane #(
    parameter int unsigned MAX_NUM_LANES  = 4,
    parameter bit          IS_UPSTREAM    = 1'b1,
    parameter logic [7:0]  LINK_NUM       = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 6000000
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   en_i,
    input  logic [MAX_NUM_LANES-1:0]               lane_detected_i,
    input  logic [MAX_NUM_LANES-1:0]               ts1_valid_i,
    input  logic [MAX_NUM_LANES-1:0]               ts2_valid_i,
    input  logic [MAX_NUM_LANES-1:0]               idle_valid_i,
    input  logic [MAX_NUM_LANES*8-1:0]             link_num_i,
    input  logic [MAX_NUM_LANES*8-1:0]             lane_num_i,
    input  logic                                   ts_sent_i,
    input  logic                                   idle_sent_i,
    output logic [1:0]                             tx_type_o,
    output logic [7:0]                             tx_link_num_o,
    output logic                                   tx_lane_pad_o,
    output logic [MAX_NUM_LANES-1:0]               lane_active_o,
    output logic [$clog2(MAX_NUM_LANES+1)-1:0]     link_width_o,
    output logic                                   lane_reversed_o,
    output logic [2:0]                             state_o,
    output logic                                   success_o,
    output logic                                   error_o
);

    localparam int unsigned N     = MAX_NUM_LANES;
    localparam int unsigned W     = $clog2(MAX_NUM_LANES + 1);
    localparam int          LOG_N = $clog2(MAX_NUM_LANES);
    localparam int unsigned TMO_W = 24;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] PAD = 8'hF7;

    localparam logic [1:0] TX_NONE = 2'd0;
    localparam logic [1:0] TX_TS1  = 2'd1;
    localparam logic [1:0] TX_TS2  = 2'd2;
    localparam logic [1:0] TX_IDLE = 2'd3;

    localparam logic [3:0] RX_TARGET = 4'd8;
    localparam logic [4:0] TX_TARGET = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LW_START  = 3'd1,
        S_LW_ACCEPT = 3'd2,
        S_LN_WAIT   = 3'd3,
        S_LN_ACCEPT = 3'd4,
        S_COMPLETE  = 3'd5,
        S_CFG_IDLE  = 3'd6,
        S_DONE      = 3'd7
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             link_q, link_d;
    logic                   retry_q, retry_d;
    logic [N-1:0]           seen_q, seen_d;
    logic [N-1:0][7:0]      lnum_q, lnum_d;
    logic [3:0]             rx_cnt_q, rx_cnt_d;
    logic [4:0]             tx_cnt_q, tx_cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [1:0]             tx_type_q, tx_type_d;
    logic [7:0]             tx_link_q, tx_link_d;
    logic                   tx_pad_q, tx_pad_d;
    logic [N-1:0]           act_q, act_d;
    logic [W-1:0]           width_q, width_d;
    logic                   rev_q, rev_d;
    logic                   success_q, success_d;
    logic                   error_q, error_d;

    logic [N-1:0][7:0]      rx_link;
    logic [N-1:0][7:0]      rx_lane;
    logic [N-1:0]           q_start, q_acc, q_lane, link_ok;
    logic [7:0]             cap_link;
    logic [W-1:0]           k_cnt, k_width;
    logic [N-1:0]           k_mask;
    logic                   k_run;
    logic                   norm_ok, rev_ok;
    logic                   all_ts2, all_idle, any_ts1_act, any_ts_act;

    assign rx_link = link_num_i;
    assign rx_lane = lane_num_i;

    // Per-lane qualification terms and the derived link-width / lane-number checks
    always_comb begin
        cap_link = PAD;
        for (int i = 0; i < int'(N); i++) begin
            q_start[i] = lane_detected_i[i] & ts1_valid_i[i] &
                         (IS_UPSTREAM ? (rx_link[i] != PAD) : (rx_link[i] == LINK_NUM));
            link_ok[i] = (rx_link[i] == link_q);
            q_acc[i]   = lane_detected_i[i] & ts1_valid_i[i] & link_ok[i];
            q_lane[i]  = (ts1_valid_i[i] | ts2_valid_i[i]) & (rx_lane[i] != PAD);
        end
        // Descending scan so the lowest qualifying lane wins
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (q_start[i]) cap_link = rx_link[i];
        end

        k_cnt = '0;
        k_run = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            if (k_run && q_acc[i]) k_cnt = k_cnt + W'(1);
            else                   k_run = 1'b0;
        end
        k_width = '0;
        for (int j = 0; j <= LOG_N; j++) begin
            if ((1 << j) <= int'(k_cnt)) k_width = W'(1 << j);
        end
        for (int i = 0; i < int'(N); i++) begin
            k_mask[i] = (i < int'(k_width));
        end

        norm_ok = 1'b1;
        rev_ok  = (width_q > W'(1));
        for (int i = 0; i < int'(N); i++) begin
            if (act_q[i]) begin
                if (lnum_q[i] != 8'(i)) norm_ok = 1'b0;
                if (lnum_q[i] != (8'(width_q) - 8'(i) - 8'd1)) rev_ok = 1'b0;
            end
        end

        all_ts2     = ((ts2_valid_i & link_ok & act_q) == act_q);
        all_idle    = ((idle_valid_i & act_q) == act_q);
        any_ts1_act = |(ts1_valid_i & act_q);
        any_ts_act  = |((ts1_valid_i | ts2_valid_i) & act_q);
    end

    // Next-state, counters and registered-output values
    always_comb begin
        state_d   = state_q;
        link_d    = link_q;
        retry_d   = retry_q;
        seen_d    = seen_q;
        lnum_d    = lnum_q;
        rx_cnt_d  = rx_cnt_q;
        tx_cnt_d  = tx_cnt_q;
        tmo_d     = tmo_q;
        act_d     = act_q;
        width_d   = width_q;
        rev_d     = rev_q;
        tx_type_d = tx_type_q;
        tx_link_d = tx_link_q;
        tx_pad_d  = tx_pad_q;
        success_d = 1'b0;
        error_d   = 1'b0;

        if (state_q != S_IDLE && state_q != S_DONE && tmo_q != '1) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (en_i) state_d = S_LW_START;
            end
            S_LW_START: begin
                if (|q_start) begin
                    link_d  = cap_link;
                    state_d = S_LW_ACCEPT;
                end
            end
            S_LW_ACCEPT: begin
                if (k_cnt != '0) begin
                    width_d = k_width;
                    act_d   = k_mask;
                    state_d = S_LN_WAIT;
                end
            end
            S_LN_WAIT: begin
                for (int i = 0; i < int'(N); i++) begin
                    if (q_lane[i]) begin
                        seen_d[i] = 1'b1;
                        lnum_d[i] = rx_lane[i];
                    end
                end
                if ((seen_d & act_q) == act_q) state_d = S_LN_ACCEPT;
            end
            S_LN_ACCEPT: begin
                if (norm_ok) begin
                    rev_d   = 1'b0;
                    state_d = S_COMPLETE;
                end else if (rev_ok) begin
                    rev_d   = 1'b1;
                    state_d = S_COMPLETE;
                end else if (!retry_q) begin
                    retry_d = 1'b1;
                    state_d = S_LW_START;
                end else begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_COMPLETE: begin
                if (any_ts1_act)                            rx_cnt_d = '0;
                else if (all_ts2 && rx_cnt_q != RX_TARGET)  rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == RX_TARGET && ts_sent_i && tx_cnt_q != TX_TARGET) begin
                    tx_cnt_d = tx_cnt_q + 5'd1;
                    if (tx_cnt_d == TX_TARGET) state_d = S_CFG_IDLE;
                end
            end
            S_CFG_IDLE: begin
                if (any_ts_act)                              rx_cnt_d = '0;
                else if (all_idle && rx_cnt_q != RX_TARGET)  rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == RX_TARGET && idle_sent_i && tx_cnt_q != TX_TARGET) begin
                    tx_cnt_d = tx_cnt_q + 5'd1;
                    if (tx_cnt_d == TX_TARGET) state_d = S_DONE;
                end
            end
            S_DONE: begin
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && state_q != S_DONE && tmo_q == TMO_LAST) begin
            error_d = 1'b1;
            state_d = S_IDLE;
        end

        // Dropping enable is an orderly abort, never an error
        if (!en_i) begin
            error_d = 1'b0;
            state_d = S_IDLE;
        end

        if (state_d != state_q) begin
            tmo_d    = '0;
            rx_cnt_d = '0;
            tx_cnt_d = '0;
            seen_d   = '0;
        end

        if (state_d == S_IDLE) begin
            act_d   = '0;
            width_d = '0;
            rev_d   = 1'b0;
            retry_d = 1'b0;
            link_d  = PAD;
        end

        // Transmit controls follow the state being entered
        case (state_d)
            S_IDLE: begin
                tx_type_d = TX_NONE;
                tx_link_d = PAD;
                tx_pad_d  = 1'b1;
            end
            S_LW_START: begin
                tx_type_d = TX_TS1;
                tx_link_d = IS_UPSTREAM ? PAD : LINK_NUM;
                tx_pad_d  = 1'b1;
            end
            S_LW_ACCEPT: begin
                tx_type_d = TX_TS1;
                tx_link_d = link_d;
                tx_pad_d  = 1'b1;
            end
            S_LN_WAIT, S_LN_ACCEPT: begin
                tx_type_d = TX_TS1;
                tx_link_d = link_d;
                tx_pad_d  = 1'b0;
            end
            S_COMPLETE: begin
                tx_type_d = TX_TS2;
                tx_link_d = link_d;
                tx_pad_d  = 1'b0;
            end
            S_CFG_IDLE: begin
                tx_type_d = TX_IDLE;
                tx_link_d = link_d;
                tx_pad_d  = 1'b0;
            end
            default: begin
                tx_type_d = TX_NONE;
                success_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            link_q    <= PAD;
            retry_q   <= 1'b0;
            seen_q    <= '0;
            lnum_q    <= '0;
            rx_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            tmo_q     <= '0;
            act_q     <= '0;
            width_q   <= '0;
            rev_q     <= 1'b0;
            tx_type_q <= TX_NONE;
            tx_link_q <= PAD;
            tx_pad_q  <= 1'b1;
            success_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            link_q    <= link_d;
            retry_q   <= retry_d;
            seen_q    <= seen_d;
            lnum_q    <= lnum_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            tmo_q     <= tmo_d;
            act_q     <= act_d;
            width_q   <= width_d;
            rev_q     <= rev_d;
            tx_type_q <= tx_type_d;
            tx_link_q <= tx_link_d;
            tx_pad_q  <= tx_pad_d;
            success_q <= success_d;
            error_q   <= error_d;
        end
    end

    assign tx_type_o       = tx_type_q;
    assign tx_link_num_o   = tx_link_q;
    assign tx_lane_pad_o   = tx_pad_q;
    assign lane_active_o   = act_q;
    assign link_width_o    = width_q;
    assign lane_reversed_o = rev_q;
    assign state_o         = state_q;
    assign success_o       = success_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_ltssm_config_multilane.sv
// Directed bench for ltssm_config_multilane: 4-lane upstream port, short timeout.
module tb_ltssm_config_multilane;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  det, ts1, ts2, idl;
    logic [31:0] link_num, lane_num;
    logic        ts_sent, idle_sent;
    logic [1:0]  tx_type;
    logic [7:0]  tx_link;
    logic        tx_pad;
    logic [3:0]  active;
    logic [2:0]  width;
    logic        reversed;
    logic [2:0]  state;
    logic        success;
    logic        error;

    int checks   = 0;
    int failures = 0;

    ltssm_config_multilane #(
        .MAX_NUM_LANES (4),
        .IS_UPSTREAM   (1'b1),
        .LINK_NUM      (8'h00),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .lane_detected_i(det),
        .ts1_valid_i    (ts1),
        .ts2_valid_i    (ts2),
        .idle_valid_i   (idl),
        .link_num_i     (link_num),
        .lane_num_i     (lane_num),
        .ts_sent_i      (ts_sent),
        .idle_sent_i    (idle_sent),
        .tx_type_o      (tx_type),
        .tx_link_num_o  (tx_link),
        .tx_lane_pad_o  (tx_pad),
        .lane_active_o  (active),
        .link_width_o   (width),
        .lane_reversed_o(reversed),
        .state_o        (state),
        .success_o      (success),
        .error_o        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},   32'(state),    32'd0);
        chk({tag, "_txtype"},  32'(tx_type),  32'd0);
        chk({tag, "_txlink"},  32'(tx_link),  32'hF7);
        chk({tag, "_txpad"},   32'(tx_pad),   32'd1);
        chk({tag, "_active"},  32'(active),   32'd0);
        chk({tag, "_width"},   32'(width),    32'd0);
        chk({tag, "_rev"},     32'(reversed), 32'd0);
        chk({tag, "_success"}, 32'(success),  32'd0);
        chk({tag, "_error"},   32'(error),    32'd0);
    endtask

    // From IDLE with en high: TS1 link 05 on all lanes through LW_START/LW_ACCEPT to LN_WAIT
    task automatic to_ln_wait(input logic [3:0] ts1_mask);
        ts1 = 4'h0; ts2 = 4'h0; idl = 4'h0;
        link_num = 32'h05050505; lane_num = 32'hF7F7F7F7;
        en = 1'b1;
        step(1);
        ts1 = ts1_mask;
        step(2);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; det = 4'hF;
        ts1 = 4'h0; ts2 = 4'h0; idl = 4'h0;
        link_num = 32'hF7F7F7F7; lane_num = 32'hF7F7F7F7;
        ts_sent = 1'b0; idle_sent = 1'b0;
        step(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        step(1);

        // Full x4 negotiation, normal lane order
        en = 1'b1;
        step(1);
        chk("lws_state", 32'(state), 32'd1);
        chk("lws_txtype", 32'(tx_type), 32'd1);
        chk("lws_txlink", 32'(tx_link), 32'hF7);
        chk("lws_txpad", 32'(tx_pad), 32'd1);
        ts1 = 4'hF; link_num = 32'h05050505;
        step(1);
        chk("lwa_state", 32'(state), 32'd2);
        step(1);
        chk("lnw_state", 32'(state), 32'd3);
        chk("x4_width", 32'(width), 32'd4);
        chk("x4_active", 32'(active), 32'hF);
        chk("lnw_txlink", 32'(tx_link), 32'h05);
        chk("lnw_txpad", 32'(tx_pad), 32'd0);
        lane_num = 32'h03020100;
        step(1);
        chk("lna_state", 32'(state), 32'd4);
        ts1 = 4'h0;
        step(1);
        chk("cpl_state", 32'(state), 32'd5);
        chk("cpl_rev", 32'(reversed), 32'd0);
        chk("cpl_txtype", 32'(tx_type), 32'd2);
        ts2 = 4'hF;
        step(8);
        ts2 = 4'h0; ts_sent = 1'b1;
        step(15);
        chk("cpl_15sent", 32'(state), 32'd5);
        step(1);
        ts_sent = 1'b0;
        chk("cfgi_state", 32'(state), 32'd6);
        chk("cfgi_txtype", 32'(tx_type), 32'd3);
        idl = 4'hF;
        step(8);
        idl = 4'h0; idle_sent = 1'b1;
        step(15);
        chk("cfgi_15sent", 32'(state), 32'd6);
        step(1);
        idle_sent = 1'b0;
        chk("done_state", 32'(state), 32'd7);
        chk("done_success", 32'(success), 32'd1);
        chk("done_txtype", 32'(tx_type), 32'd0);
        chk("done_active", 32'(active), 32'hF);
        chk("done_width", 32'(width), 32'd4);
        chk("done_txlink", 32'(tx_link), 32'h05);
        step(3);
        chk("done_hold", 32'(state), 32'd7);
        en = 1'b0;
        step(1);
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_error", 32'(error), 32'd0);
        chk("dis_width", 32'(width), 32'd0);
        chk("dis_success", 32'(success), 32'd0);

        // Lanes 0..2 qualify -> x2; lane 3 noise ignored; TS1 mid-count clears COMPLETE count
        to_ln_wait(4'b0111);
        chk("x2_state", 32'(state), 32'd3);
        chk("x2_width", 32'(width), 32'd2);
        chk("x2_active", 32'(active), 32'h3);
        ts1 = 4'b1011; lane_num = 32'h07F70100;
        step(2);
        chk("x2_cpl", 32'(state), 32'd5);
        chk("x2_rev", 32'(reversed), 32'd0);
        ts1 = 4'b1000; ts2 = 4'b0011;
        step(7);
        ts1 = 4'b1001; ts2 = 4'b0000;
        step(1);
        ts1 = 4'b1000; ts2 = 4'b0011;
        step(7);
        ts2 = 4'b0000; ts_sent = 1'b1;
        step(16);
        ts_sent = 1'b0;
        chk("clr_hold", 32'(state), 32'd5);
        ts2 = 4'b0011;
        step(1);
        ts2 = 4'b0000; ts_sent = 1'b1;
        step(16);
        ts_sent = 1'b0; ts1 = 4'h0;
        chk("clr_adv", 32'(state), 32'd6);
        en = 1'b0;
        step(1);

        // Reversed lane numbers
        to_ln_wait(4'hF);
        lane_num = 32'h00010203;
        step(2);
        chk("rev_state", 32'(state), 32'd5);
        chk("rev_flag", 32'(reversed), 32'd1);
        en = 1'b0;
        step(1);
        chk("rev_clear", 32'(reversed), 32'd0);

        // Lane-number mismatch: retry once, then error
        to_ln_wait(4'hF);
        lane_num = 32'h03010200;
        step(2);
        chk("mm1_state", 32'(state), 32'd1);
        chk("mm1_error", 32'(error), 32'd0);
        step(3);
        chk("mm2_lna", 32'(state), 32'd4);
        step(1);
        chk("mm2_state", 32'(state), 32'd0);
        chk("mm2_error", 32'(error), 32'd1);
        ts1 = 4'h0;
        step(1);
        chk("mm2_pulse", 32'(error), 32'd0);
        en = 1'b0;
        step(1);

        // Timeout with no TS1: 100 cycles after LW_START entry
        en = 1'b1;
        step(1);
        chk("tmo_entry", 32'(state), 32'd1);
        step(99);
        chk("tmo_99", 32'(state), 32'd1);
        chk("tmo_99_err", 32'(error), 32'd0);
        step(1);
        chk("tmo_state", 32'(state), 32'd0);
        chk("tmo_error", 32'(error), 32'd1);
        step(1);
        chk("tmo_pulse", 32'(error), 32'd0);
        en = 1'b0;
        step(1);

        // Asynchronous reset while in CFG_IDLE
        to_ln_wait(4'hF);
        lane_num = 32'h03020100;
        step(2);
        ts1 = 4'h0; ts2 = 4'hF;
        step(8);
        ts2 = 4'h0; ts_sent = 1'b1;
        step(16);
        ts_sent = 1'b0;
        chk("pre_rst", 32'(state), 32'd6);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        step(1);
        rst = 1'b0; en = 1'b0;
        step(1);
        en = 1'b1;
        step(1);
        chk("resume", 32'(state), 32'd1);
        en = 1'b0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
